seq_pattern_counter: RTL and testbench

- Parametrised serial bit-stream pattern detector with event and ones counters.
- Successor to the fixed 3-bit-state detector/up-counter driven by the serial `b` stimulus bench.
- Pattern value, pattern length, overlap mode, counter width and overflow mode are all generic; adds a sample-enable, a synchronous clear and overflow flagging.
- Sits between a serial bit source and status/display logic; one bit is consumed per enabled clock.

---
 rtl/seq_pattern_counter.sv | 155 +++++++++++++++
 tb/tb_seq_pattern_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter: serial pattern detector with match and ones counters.
// The detector state is the length of the longest pattern prefix that is a
// suffix of the sampled stream. The transition table is derived from PAT while
// the design elaborates, using a KMP-style failure function.
//
// Sampling protocol: en qualifies b. A bit is consumed on every rising edge
// where en=1 and clr=0. There is no backpressure. clr overrides en, and en=0
// holds every state except the one-cycle match pulse.
module seq_pattern_counter #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT     = 4'b1011,
  parameter int               CNT_W   = 4,
  parameter int               OVERLAP = 1,
  parameter int               SAT     = 1,
  localparam int              ST_W    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic [ST_W-1:0]  y,
  output logic             match,
  output logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] s,
  output logic             ovf
);

  // Pattern bit j in arrival order. The MSB of PAT arrives first.
  function automatic logic pat_bit(input int j);
    logic [PAT_W-1:0] v;
    v = PAT >> (PAT_W - 1 - j);
    return v[0];
  endfunction

  // The first len bits of the pattern, right-aligned.
  function automatic logic [31:0] prefix(input int len);
    logic [31:0] p;
    p = 32'(PAT);
    return (len == 0) ? 32'd0 : (p >> (PAT_W - len));
  endfunction

  // Failure function: the length of the longest proper border of prefix(len).
  function automatic int border(input int len);
    int          best;
    logic [31:0] mask;
    best = 0;
    for (int w = 1; w < len; w++) begin
      mask = (32'd1 << w) - 32'd1;
      if ((prefix(len) & mask) == prefix(w)) best = w;
    end
    return best;
  endfunction

  // Next prefix length after bit_in arrives in state k (k < PAT_W).
  // The detector falls back through the failure function until the next
  // pattern bit matches bit_in or the length reaches 0.
  function automatic int next_len(input int k, input logic bit_in);
    int j;
    j = k;
    for (int t = 0; t < PAT_W; t++) begin
      if (j > 0 && pat_bit(j) != bit_in) j = border(j);
    end
    if (pat_bit(j) == bit_in) j = j + 1;
    return j;
  endfunction

  // FULL is the state reached when a match completes. It is never stored,
  // because a completed match reloads RESTART instead.
  localparam logic [ST_W-1:0] FULL    = ST_W'(PAT_W);
  localparam logic [ST_W-1:0] RESTART = (OVERLAP != 0) ? ST_W'(border(PAT_W)) : '0;

  // Precomputed transition table, indexed by the current prefix length.
  logic [ST_W-1:0] w_nxt0 [PAT_W+1];
  logic [ST_W-1:0] w_nxt1 [PAT_W+1];

  for (genvar g = 0; g < PAT_W; g++) begin : g_tbl
    localparam int N0 = next_len(g, 1'b0);
    localparam int N1 = next_len(g, 1'b1);
    assign w_nxt0[g] = ST_W'(N0);
    assign w_nxt1[g] = ST_W'(N1);
  end
  // The state register never holds PAT_W, so this entry is never used.
  assign w_nxt0[PAT_W] = '0;
  assign w_nxt1[PAT_W] = '0;

  logic [ST_W-1:0]  r_y, w_y_nxt, w_k;
  logic             r_match, w_match_nxt;
  logic [CNT_W-1:0] r_n, w_n_nxt;
  logic [CNT_W-1:0] r_s, w_s_nxt;
  logic             r_ovf, w_ovf_nxt;

  // State and counter registers. Reset clears them immediately, without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y     <= '0;
      r_match <= 1'b0;
      r_n     <= '0;
      r_s     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_y     <= w_y_nxt;
      r_match <= w_match_nxt;
      r_n     <= w_n_nxt;
      r_s     <= w_s_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state logic. The priority is clr, then en, then hold.
  // Each counter either saturates or wraps; a wrap sets the sticky ovf flag.
  always_comb begin
    w_y_nxt     = r_y;
    w_match_nxt = 1'b0;
    w_n_nxt     = r_n;
    w_s_nxt     = r_s;
    w_ovf_nxt   = r_ovf;
    w_k         = w_nxt0[r_y];
    if (clr) begin
      w_y_nxt   = '0;
      w_n_nxt   = '0;
      w_s_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (en) begin
      w_k = b ? w_nxt1[r_y] : w_nxt0[r_y];
      if (w_k == FULL) begin
        w_y_nxt     = RESTART;
        w_match_nxt = 1'b1;
        if (r_n != '1) begin
          w_n_nxt = r_n + 1'b1;
        end else if (SAT == 0) begin
          w_n_nxt   = '0;
          w_ovf_nxt = 1'b1;
        end
      end else begin
        w_y_nxt = w_k;
      end
      if (b) begin
        if (r_s != '1) begin
          w_s_nxt = r_s + 1'b1;
        end else if (SAT == 0) begin
          w_s_nxt   = '0;
          w_ovf_nxt = 1'b1;
        end
      end
    end
  end

  assign y     = r_y;
  assign match = r_match;
  assign n     = r_n;
  assign s     = r_s;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Testbench for seq_pattern_counter. Four instances share one input stream:
//   u_a: PAT=1011, OVERLAP=1, SAT=1
//   u_b: PAT=1011, OVERLAP=0, SAT=1
//   u_c: PAT=1111, OVERLAP=1, SAT=1
//   u_d: PAT=1111, OVERLAP=1, SAT=0
module tb_seq_pattern_counter;

  localparam int OBS_W = 13; // {y[2:0], match, n[3:0], s[3:0], ovf}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, b, en, clr;
  always #5 clk = ~clk;

  logic [2:0] a_y, b_y, c_y, d_y;
  logic       a_m, b_m, c_m, d_m;
  logic [3:0] a_n, b_n, c_n, d_n;
  logic [3:0] a_s, b_s, c_s, d_s;
  logic       a_ovf, b_ovf, c_ovf, d_ovf;

  seq_pattern_counter #(.PAT_W(4), .PAT(4'b1011), .CNT_W(4), .OVERLAP(1), .SAT(1)) u_a (
    .clk(clk), .rst(rst), .b(b), .en(en), .clr(clr),
    .y(a_y), .match(a_m), .n(a_n), .s(a_s), .ovf(a_ovf));
  seq_pattern_counter #(.PAT_W(4), .PAT(4'b1011), .CNT_W(4), .OVERLAP(0), .SAT(1)) u_b (
    .clk(clk), .rst(rst), .b(b), .en(en), .clr(clr),
    .y(b_y), .match(b_m), .n(b_n), .s(b_s), .ovf(b_ovf));
  seq_pattern_counter #(.PAT_W(4), .PAT(4'b1111), .CNT_W(4), .OVERLAP(1), .SAT(1)) u_c (
    .clk(clk), .rst(rst), .b(b), .en(en), .clr(clr),
    .y(c_y), .match(c_m), .n(c_n), .s(c_s), .ovf(c_ovf));
  seq_pattern_counter #(.PAT_W(4), .PAT(4'b1111), .CNT_W(4), .OVERLAP(1), .SAT(0)) u_d (
    .clk(clk), .rst(rst), .b(b), .en(en), .clr(clr),
    .y(d_y), .match(d_m), .n(d_n), .s(d_s), .ovf(d_ovf));

  // ---------------- vector table ----------------
  typedef struct {
    logic       b;
    logic       en;
    logic       clr;
    logic [2:0] y;
    logic       m;
    logic [3:0] n;
    logic [3:0] s;
    logic       ovf;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  logic [OBS_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  int stream_bits [7] = '{1, 0, 1, 1, 0, 1, 1};
  int exp_ay      [7] = '{1, 2, 3, 1, 2, 3, 1};
  int exp_am      [7] = '{0, 0, 0, 1, 0, 0, 1};
  int exp_by      [7] = '{1, 2, 3, 0, 0, 1, 1};
  int exp_bm      [7] = '{0, 0, 0, 1, 0, 0, 0};
  int rst_bits    [4] = '{1, 0, 1, 1};
  int rst_y       [4] = '{1, 2, 3, 1};
  int rst_m       [4] = '{0, 0, 0, 1};

  task automatic add(input int bv, input int env, input int clrv, input int y,
                     input int m, input int nv, input int sv, input int ovf,
                     input string tag);
    vec_t v;
    v.b = 1'(bv); v.en = 1'(env); v.clr = 1'(clrv);
    v.y = 3'(y); v.m = 1'(m); v.n = 4'(nv); v.s = 4'(sv); v.ovf = 1'(ovf);
    v.tag = tag;
    vecs.push_back(v);
  endtask

  // One enabled bit, then three en=0 cycles with random b. Those cycles must
  // hold every output and drop match.
  task automatic add_gapped(input int bv, input int y, input int m,
                            input int nv, input int sv, input string tag);
    add(bv, 1, 0, y, m, nv, sv, 0, tag);
    for (int g = 0; g < 3; g++)
      add(int'($urandom_range(0, 1)), 0, 0, y, 0, nv, sv, 0, {tag, "_gap"});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic bv, input logic env, input logic clrv);
    @(negedge clk);
    b = bv; en = env; clr = clrv;
    @(posedge clk);
    #1;
  endtask

  // ---------------- checks / scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [OBS_W-1:0] e, a;
    total++;
    a = {a_y, a_m, a_n, a_s, a_ovf};
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s got y=%0d m=%0d n=%0d s=%0d ovf=%0d exp y=%0d m=%0d n=%0d s=%0d ovf=%0d",
                 name, a[12:10], a[9], a[8:5], a[4:1], a[0],
                 e[12:10], e[9], e[8:5], e[4:1], e[0]);
      end
    end
  endtask

  // Watchdog: guarantees the run ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; b = 1'b0; en = 1'b0; clr = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_a_y", a_y, 0);   check("rst_a_m", a_m, 0);
    check("rst_a_n", a_n, 0);   check("rst_a_s", a_s, 0);
    check("rst_a_ovf", a_ovf, 0);
    check("rst_d_ovf", d_ovf, 0); check("rst_d_n", d_n, 0);
    // Drive a 1 with en=1 while reset is held; it must not be sampled.
    b = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_a_s", a_s, 0); check("rst_hold_a_y", a_y, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; b = 1'b0;

    // Table contents, checked against u_a (PAT=1011, OVERLAP=1, SAT=1).
    // Stream 1,0,1,0,1,0,1,1.
    add(1, 1, 0, 1, 0, 0, 1, 0, "a1");
    add(0, 1, 0, 2, 0, 0, 1, 0, "a2");
    add(1, 1, 0, 3, 0, 0, 2, 0, "a3");
    add(0, 1, 0, 2, 0, 0, 2, 0, "a4");
    add(1, 1, 0, 3, 0, 0, 3, 0, "a5");
    add(0, 1, 0, 2, 0, 0, 3, 0, "a6");
    add(1, 1, 0, 3, 0, 0, 4, 0, "a7");
    add(1, 1, 0, 1, 1, 1, 5, 0, "a8_match");
    add(0, 0, 0, 1, 0, 1, 5, 0, "a_idle");
    add(1, 1, 1, 0, 0, 0, 0, 0, "a_clr");
    // Stream 1011011 with 3 idle cycles after every bit.
    add_gapped(1, 1, 0, 0, 1, "g1");
    add_gapped(0, 2, 0, 0, 1, "g2");
    add_gapped(1, 3, 0, 0, 2, "g3");
    add_gapped(1, 1, 1, 1, 3, "g4_match");
    add_gapped(0, 2, 0, 1, 3, "g5");
    add_gapped(1, 3, 0, 1, 4, "g6");
    add_gapped(1, 1, 1, 2, 5, "g7_match");
    // Walk to y=3 with n=2, then clr together with en=1, b=1.
    add(0, 1, 0, 2, 0, 2, 5, 0, "c0");
    add(1, 1, 0, 3, 0, 2, 6, 0, "c1_y3");
    add(1, 1, 1, 0, 0, 0, 0, 0, "c_clr_wins");
    add(1, 1, 0, 1, 0, 0, 1, 0, "c_after");

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].y, vecs[i].m, vecs[i].n, vecs[i].s, vecs[i].ovf});
      step(vecs[i].b, vecs[i].en, vecs[i].clr);
      sb_check($sformatf("vec%0d_%s", i, vecs[i].tag));
    end

    // Gapless 1011011: overlap vs restart.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'(stream_bits[i]), 1'b1, 1'b0);
      check($sformatf("ov_y_%0d", i), a_y, exp_ay[i]);
      check($sformatf("ov_m_%0d", i), a_m, exp_am[i]);
      check($sformatf("nov_y_%0d", i), b_y, exp_by[i]);
      check($sformatf("nov_m_%0d", i), b_m, exp_bm[i]);
    end
    check("ov_final_n", a_n, 2);  check("ov_final_s", a_s, 5);
    check("nov_final_n", b_n, 1); check("nov_final_s", b_s, 5);

    // Asynchronous reset mid-stream after bits 1,0,1.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("pre_rst_a_y", a_y, 3);
    check("pre_rst_a_s", a_s, 7);
    #2 rst = 1'b0;
    #1;
    check("async_a_y", a_y, 0); check("async_a_n", a_n, 0);
    check("async_a_s", a_s, 0); check("async_a_m", a_m, 0);
    check("async_b_n", b_n, 0); check("async_d_s", d_s, 0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_low_a_y", a_y, 0); check("rst_low_a_s", a_s, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'(rst_bits[i]), 1'b1, 1'b0);
      check($sformatf("post_rst_y_%0d", i), a_y, rst_y[i]);
      check($sformatf("post_rst_m_%0d", i), a_m, rst_m[i]);
    end
    check("post_rst_n", a_n, 1); check("post_rst_s", a_s, 3);

    // 32 consecutive ones: saturating vs wrapping counters.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 3) begin
        check("ones_first_match_m", c_m, 1);
        check("ones_first_match_n", c_n, 1);
      end
      if (i == 14) begin
        check("wrap_pre_s", d_s, 15);
        check("wrap_pre_ovf", d_ovf, 0);
      end
      if (i == 15) begin
        check("wrap_s", d_s, 0);
        check("wrap_ovf", d_ovf, 1);
        check("sat_s16", c_s, 15);
      end
    end
    check("sat_n", c_n, 15); check("sat_s", c_s, 15);
    check("sat_ovf", c_ovf, 0); check("sat_y", c_y, 3);
    check("wrap_n", d_n, 13); check("wrap_final_s", d_s, 0);
    check("wrap_final_ovf", d_ovf, 1);
    step(1'b1, 1'b0, 1'b0);
    check("ovf_sticky", d_ovf, 1); check("idle_m", d_m, 0);
    step(1'b0, 1'b0, 1'b1);
    check("clr_ovf", d_ovf, 0); check("clr_n", d_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
